// File: rtl/pcx2mb_pkg.sv
// Shared definitions for the PCX-to-MicroBlaze grant scheduler.
//   PCX2MB_NUM_DEST    number of PCX destinations
//   PCX2MB_DEPTH       pending entries per destination queue
//   PCX2MB_MB_CREDITS  downstream packet credits after reset
//   sched_state_e      scheduler FSM states
//   onehot2idx         one-hot (up to 8 bits) to binary index
package pcx2mb_pkg;

  localparam int PCX2MB_NUM_DEST   = 5;
  localparam int PCX2MB_DEPTH      = 2;
  localparam int PCX2MB_MB_CREDITS = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    ATOM2 = 1'b1
  } sched_state_e;

  // Callers zero-extend narrower vectors; an all-zero input returns 0.
  function automatic logic [2:0] onehot2idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/pcx2mb_dest_q.sv
// Per-destination pending-request queue: a DEPTH-entry FIFO of atom bits.
//   clk, rst    clock, asynchronous active-high reset
//   push        request for this destination (already qualified one-hot)
//   push_atom   atom bit stored with the request
//   pop         remove the head entry (only asserted when non-empty)
//   empty       queue holds no entries
//   head_atom   atom bit of the head entry
//   drop        registered pulse: a push found the queue full and was discarded
module pcx2mb_dest_q
  import pcx2mb_pkg::*;
#(
  parameter int DEPTH = PCX2MB_DEPTH
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic push_atom,
  input  logic pop,
  output logic empty,
  output logic head_atom,
  output logic drop
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0]    cnt, cnt_nxt, wr_pos;
  logic [DEPTH-1:0] mem, mem_nxt;
  logic             full, accept;

  assign full      = (cnt == CW'(DEPTH));
  assign empty     = (cnt == '0);
  assign head_atom = mem[0];

  // A full queue still accepts when its head leaves in the same cycle.
  assign accept = push && (!full || pop);
  // Entry 0 is the head; popping shifts everything down one slot first.
  assign wr_pos = pop ? (cnt - 1'b1) : cnt;

  always_comb begin
    mem_nxt = mem;
    if (pop) mem_nxt = mem >> 1;
    for (int i = 0; i < DEPTH; i++) begin
      if (accept && (wr_pos == CW'(i))) mem_nxt[i] = push_atom;
    end
    cnt_nxt = cnt;
    if (accept && !pop) cnt_nxt = cnt + 1'b1;
    else if (pop && !accept) cnt_nxt = cnt - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      mem  <= '0;
      drop <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      mem  <= mem_nxt;
      drop <= push && !accept;
    end
  end

endmodule

// File: rtl/pcx2mb_grant_sched.sv
// Round-robin grant scheduler sharing one credit-controlled MicroBlaze link
// between NUM_DEST PCX destinations. Atomic requests take two back-to-back grants.
//   rclk, reset     clock, asynchronous active-high reset
//   pcx_req_pa      one-hot request (non-one-hot ignored)
//   pcx_atom_pa     request is atomic (two packets)
//   mb_credit_ret   downstream returned one packet credit
//   pcx_grant_px    registered one-hot grant
//   mb_send_px      packet issued this cycle
//   mb_dest_px      binary index of granted destination
//   mb_atom_px      high on both packets of an atomic grant
//   req_drop        pulse: request hit a full queue
//   err_credit_ovf  sticky: credit return beyond MB_CREDITS
module pcx2mb_grant_sched
  import pcx2mb_pkg::*;
#(
  parameter int NUM_DEST   = PCX2MB_NUM_DEST,
  parameter int DEPTH      = PCX2MB_DEPTH,
  parameter int MB_CREDITS = PCX2MB_MB_CREDITS
) (
  input  logic                rclk,
  input  logic                reset,
  input  logic [NUM_DEST-1:0] pcx_req_pa,
  input  logic                pcx_atom_pa,
  input  logic                mb_credit_ret,
  output logic [NUM_DEST-1:0] pcx_grant_px,
  output logic                mb_send_px,
  output logic [2:0]          mb_dest_px,
  output logic                mb_atom_px,
  output logic                req_drop,
  output logic                err_credit_ovf
);

  localparam int IW  = (NUM_DEST > 1) ? $clog2(NUM_DEST) : 1;
  localparam int CRW = $clog2(MB_CREDITS + 1);
  localparam logic [IW:0] N_EXT = (IW + 1)'(NUM_DEST);

  sched_state_e        state, state_nxt;
  logic [IW-1:0]       rr_ptr, ptr_nxt, atom_dest, atom_dest_nxt;
  logic [CRW-1:0]      credit, credit_nxt;
  logic                ovf_nxt;
  logic [NUM_DEST-1:0] grant_nxt;
  logic                atom_nxt, send;

  logic                req_valid;
  logic [NUM_DEST-1:0] push, pop, q_empty, q_head_atom, q_drop, elig, elig_rot;
  logic                pick_valid;
  logic [IW-1:0]       pick_off, pick_idx;
  logic [IW:0]         pick_sum;

  assign req_valid = (pcx_req_pa != '0) && ((pcx_req_pa & (pcx_req_pa - 1'b1)) == '0);
  assign push      = req_valid ? pcx_req_pa : '0;

  for (genvar g = 0; g < NUM_DEST; g++) begin : g_q
    pcx2mb_dest_q #(.DEPTH(DEPTH)) u_q (
      .clk       (rclk),
      .rst       (reset),
      .push      (push[g]),
      .push_atom (pcx_atom_pa),
      .pop       (pop[g]),
      .empty     (q_empty[g]),
      .head_atom (q_head_atom[g]),
      .drop      (q_drop[g])
    );
  end

  // An atomic head needs both credits up front so its second packet is guaranteed.
  always_comb begin
    for (int d = 0; d < NUM_DEST; d++) begin
      elig[d] = !q_empty[d] && (q_head_atom[d] ? (credit >= CRW'(2)) : (credit != '0));
    end
  end

  // Rotate so bit 0 is the RR pointer, take the first set bit, rotate back.
  assign elig_rot = NUM_DEST'({elig, elig} >> rr_ptr);

  always_comb begin
    pick_valid = 1'b0;
    pick_off   = '0;
    for (int k = 0; k < NUM_DEST; k++) begin
      if (!pick_valid && elig_rot[k]) begin
        pick_valid = 1'b1;
        pick_off   = IW'(k);
      end
    end
  end

  assign pick_sum = {1'b0, rr_ptr} + {1'b0, pick_off};
  assign pick_idx = (pick_sum >= N_EXT) ? IW'(pick_sum - N_EXT) : IW'(pick_sum);

  always_comb begin
    state_nxt     = state;
    pop           = '0;
    grant_nxt     = '0;
    atom_nxt      = 1'b0;
    send          = 1'b0;
    ptr_nxt       = rr_ptr;
    atom_dest_nxt = atom_dest;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          pop       = NUM_DEST'(1) << pick_idx;
          grant_nxt = NUM_DEST'(1) << pick_idx;
          atom_nxt  = q_head_atom[pick_idx];
          send      = 1'b1;
          ptr_nxt   = (pick_idx == IW'(NUM_DEST - 1)) ? '0 : pick_idx + 1'b1;
          if (q_head_atom[pick_idx]) begin
            state_nxt     = ATOM2;
            atom_dest_nxt = pick_idx;
          end
        end
      end
      ATOM2: begin
        grant_nxt = NUM_DEST'(1) << atom_dest;
        atom_nxt  = 1'b1;
        send      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    credit_nxt = credit;
    ovf_nxt    = err_credit_ovf;
    case ({send, mb_credit_ret})
      2'b10: credit_nxt = credit - 1'b1;
      2'b01: begin
        if (credit == CRW'(MB_CREDITS)) ovf_nxt = 1'b1;
        else credit_nxt = credit + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge rclk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge rclk or posedge reset) begin
    if (reset) begin
      rr_ptr         <= '0;
      atom_dest      <= '0;
      credit         <= CRW'(MB_CREDITS);
      err_credit_ovf <= 1'b0;
      pcx_grant_px   <= '0;
      mb_atom_px     <= 1'b0;
    end else begin
      rr_ptr         <= ptr_nxt;
      atom_dest      <= atom_dest_nxt;
      credit         <= credit_nxt;
      err_credit_ovf <= ovf_nxt;
      pcx_grant_px   <= grant_nxt;
      mb_atom_px     <= atom_nxt;
    end
  end

  assign mb_send_px = |pcx_grant_px;
  assign mb_dest_px = onehot2idx(8'(pcx_grant_px));
  assign req_drop   = |q_drop;

endmodule

// File: tb/tb_pcx2mb_grant_sched.sv
module tb_pcx2mb_grant_sched;

  logic       rclk;
  logic       reset;
  logic [4:0] pcx_req_pa;
  logic       pcx_atom_pa;
  logic       mb_credit_ret;
  logic [4:0] pcx_grant_px;
  logic       mb_send_px;
  logic [2:0] mb_dest_px;
  logic       mb_atom_px;
  logic       req_drop;
  logic       err_credit_ovf;

  int n_cmp  = 0;
  int n_fail = 0;

  pcx2mb_grant_sched dut (
    .rclk           (rclk),
    .reset          (reset),
    .pcx_req_pa     (pcx_req_pa),
    .pcx_atom_pa    (pcx_atom_pa),
    .mb_credit_ret  (mb_credit_ret),
    .pcx_grant_px   (pcx_grant_px),
    .mb_send_px     (mb_send_px),
    .mb_dest_px     (mb_dest_px),
    .mb_atom_px     (mb_atom_px),
    .req_drop       (req_drop),
    .err_credit_ovf (err_credit_ovf)
  );

  initial begin
    rclk = 1'b0;
    forever #5 rclk = ~rclk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per-destination lists, a credit count and a round-robin pointer.
  bit         mq[5][2];
  int         mn[5];
  int         mcred = 4;
  int         mptr = 0;
  bit         mpend = 0;
  int         mpd = 0;
  logic [4:0] exp_grant = '0;
  bit         exp_atom = 0;
  int         exp_dest = 0;
  bit         exp_drop = 0;
  bit         exp_ovf = 0;
  int         m_sent, m_pick, m_d, m_in;

  always @(posedge rclk or posedge reset) begin
    if (reset) begin
      for (int d = 0; d < 5; d++) mn[d] = 0;
      mcred = 4; mptr = 0; mpend = 0; mpd = 0;
      exp_grant = '0; exp_atom = 0; exp_dest = 0; exp_drop = 0; exp_ovf = 0;
    end else begin
      m_sent = 0;
      exp_grant = '0;
      exp_atom = 0;
      if (mpend) begin
        exp_grant = 5'(1) << mpd;
        exp_atom = 1;
        exp_dest = mpd;
        m_sent = 1;
        mpend = 0;
      end else begin
        m_pick = -1;
        for (int k = 0; k < 5; k++) begin
          m_d = (mptr + k) % 5;
          if (m_pick < 0 && mn[m_d] > 0 && mcred >= (mq[m_d][0] ? 2 : 1)) m_pick = m_d;
        end
        if (m_pick >= 0) begin
          exp_atom = mq[m_pick][0];
          mq[m_pick][0] = mq[m_pick][1];
          mn[m_pick]--;
          exp_grant = 5'(1) << m_pick;
          exp_dest = m_pick;
          m_sent = 1;
          mptr = (m_pick + 1) % 5;
          if (exp_atom) begin
            mpend = 1;
            mpd = m_pick;
          end
        end
      end
      exp_drop = 0;
      if ($countones(pcx_req_pa) == 1) begin
        m_in = 0;
        for (int d = 0; d < 5; d++) if (pcx_req_pa[d]) m_in = d;
        if (mn[m_in] < 2) begin
          mq[m_in][mn[m_in]] = pcx_atom_pa;
          mn[m_in]++;
        end else begin
          exp_drop = 1;
        end
      end
      mcred = mcred - m_sent + (mb_credit_ret ? 1 : 0);
      if (mcred > 4) begin
        mcred = 4;
        exp_ovf = 1;
      end
    end
  end

  always @(negedge rclk) begin
    if (!reset) begin
      check("grant", 32'(pcx_grant_px), 32'(exp_grant));
      check("send", 32'(mb_send_px), 32'(|exp_grant));
      if (exp_grant != '0) check("dest", 32'(mb_dest_px), 32'(exp_dest));
      check("atom", 32'(mb_atom_px), 32'(exp_atom));
      check("drop", 32'(req_drop), 32'(exp_drop));
      check("ovf", 32'(err_credit_ovf), 32'(exp_ovf));
    end
  end

  task automatic step(input logic [4:0] req, input logic atom, input logic ret);
    pcx_req_pa = req;
    pcx_atom_pa = atom;
    mb_credit_ret = ret;
    @(negedge rclk);
  endtask

  task automatic do_reset();
    pcx_req_pa = '0; pcx_atom_pa = 1'b0; mb_credit_ret = 1'b0;
    reset = 1'b1;
    @(negedge rclk);
    @(negedge rclk);
    reset = 1'b0;
  endtask

  // Sequential plain requests to dest 0..4 with 4 credits: 0..3 granted, 4 waits for a return.
  task automatic five_check(input string tag);
    for (int d = 0; d < 5; d++) begin
      step(5'(1) << d, 1'b0, 1'b0);
      if (d >= 1) check({tag, "_grant"}, 32'(pcx_grant_px), 32'(5'(1) << (d - 1)));
    end
    step('0, 1'b0, 1'b0);
    check({tag, "_starved"}, 32'(pcx_grant_px), 32'h0);
    step('0, 1'b0, 1'b1);
    check({tag, "_starved2"}, 32'(pcx_grant_px), 32'h0);
    step('0, 1'b0, 1'b0);
    check({tag, "_g4"}, 32'(pcx_grant_px), 32'h10);
    check({tag, "_d4"}, 32'(mb_dest_px), 32'd4);
    step('0, 1'b0, 1'b0);
  endtask

  int         cnt0;
  int         r;
  logic [4:0] rq;

  initial begin
    reset = 1'b0;
    pcx_req_pa = '0; pcx_atom_pa = 1'b0; mb_credit_ret = 1'b0;
    #1;
    do_reset();

    // reset state
    check("rst_grant", 32'(pcx_grant_px), 32'h0);
    check("rst_send", 32'(mb_send_px), 32'h0);
    check("rst_dest", 32'(mb_dest_px), 32'h0);
    check("rst_atom", 32'(mb_atom_px), 32'h0);
    check("rst_drop", 32'(req_drop), 32'h0);
    check("rst_ovf", 32'(err_credit_ovf), 32'h0);

    // 1: single request to dest 2
    step(5'b00100, 1'b0, 1'b0);
    check("t1_c1", 32'(pcx_grant_px), 32'h0);
    step('0, 1'b0, 1'b0);
    check("t1_grant", 32'(pcx_grant_px), 32'h04);
    check("t1_dest", 32'(mb_dest_px), 32'd2);
    check("t1_model_cred", 32'(mcred), 32'd3);
    step('0, 1'b0, 1'b0);

    // 2: round robin over all destinations, credits run out at dest 4
    do_reset();
    five_check("t2");

    // 3: blocked atomic to dest 1, plain dest 3 overtakes
    do_reset();
    step(5'b00001, 1'b0, 1'b0);
    step(5'b00001, 1'b0, 1'b0);
    check("t3_g0a", 32'(pcx_grant_px), 32'h01);
    step(5'b00001, 1'b0, 1'b0);
    check("t3_g0b", 32'(pcx_grant_px), 32'h01);
    step(5'b00010, 1'b1, 1'b0);
    check("t3_g0c", 32'(pcx_grant_px), 32'h01);
    step(5'b01000, 1'b0, 1'b0);
    check("t3_idle", 32'(pcx_grant_px), 32'h0);
    step('0, 1'b0, 1'b0);
    check("t3_g3", 32'(pcx_grant_px), 32'h08);
    step('0, 1'b0, 1'b1);
    check("t3_wait1", 32'(pcx_grant_px), 32'h0);
    step('0, 1'b0, 1'b1);
    check("t3_wait2", 32'(pcx_grant_px), 32'h0);
    step('0, 1'b0, 1'b0);
    check("t3_a1", 32'(pcx_grant_px), 32'h02);
    check("t3_a1_atom", 32'(mb_atom_px), 32'h1);
    step('0, 1'b0, 1'b0);
    check("t3_a2", 32'(pcx_grant_px), 32'h02);
    check("t3_a2_atom", 32'(mb_atom_px), 32'h1);
    check("t3_a2_dest", 32'(mb_dest_px), 32'd1);
    step('0, 1'b0, 1'b0);
    check("t3_done", 32'(pcx_grant_px), 32'h0);

    // 4: third request to a full queue is dropped
    do_reset();
    for (int i = 0; i < 4; i++) step(5'b00100, 1'b0, 1'b0);
    repeat (3) step('0, 1'b0, 1'b0);
    check("t4_model_cred", 32'(mcred), 32'd0);
    step(5'b00001, 1'b0, 1'b0);
    check("t4_drop1", 32'(req_drop), 32'h0);
    step(5'b00001, 1'b0, 1'b0);
    check("t4_drop2", 32'(req_drop), 32'h0);
    step(5'b00001, 1'b0, 1'b0);
    check("t4_drop3", 32'(req_drop), 32'h1);
    step('0, 1'b0, 1'b0);
    check("t4_drop_pulse", 32'(req_drop), 32'h0);
    cnt0 = 0;
    for (int i = 0; i < 8; i++) begin
      step('0, 1'b0, (i < 4) ? 1'b1 : 1'b0);
      if (pcx_grant_px == 5'b00001) cnt0++;
    end
    check("t4_queued", 32'(cnt0), 32'd2);

    // 5: reset during the second half of an atomic
    do_reset();
    step(5'b10000, 1'b1, 1'b0);
    step('0, 1'b0, 1'b0);
    check("t5_a1", 32'(pcx_grant_px), 32'h10);
    check("t5_a1_atom", 32'(mb_atom_px), 32'h1);
    #1 reset = 1'b1;
    #1;
    check("t5_rst_grant", 32'(pcx_grant_px), 32'h0);
    check("t5_rst_atom", 32'(mb_atom_px), 32'h0);
    check("t5_rst_send", 32'(mb_send_px), 32'h0);
    #1 reset = 1'b0;
    @(negedge rclk);
    check("t5_no_second", 32'(pcx_grant_px), 32'h0);
    check("t5_model_cred", 32'(mcred), 32'd4);
    five_check("t5");

    // 6: credit return at full credit saturates and latches the error
    do_reset();
    step('0, 1'b0, 1'b1);
    check("t6_ovf", 32'(err_credit_ovf), 32'h1);
    step('0, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
    check("t6_ovf_sticky", 32'(err_credit_ovf), 32'h1);
    check("t6_model_cred", 32'(mcred), 32'd4);
    five_check("t6");
    do_reset();
    check("t6_ovf_cleared", 32'(err_credit_ovf), 32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 45)      rq = 5'(1) << $urandom_range(0, 4);
      else if (r < 52) rq = 5'($urandom);
      else             rq = '0;
      if ($urandom_range(0, 399) == 0) begin
        reset = 1'b1;
        step('0, 1'b0, 1'b0);
        reset = 1'b0;
      end
      step(rq, ($urandom_range(0, 3) == 0), ($urandom_range(0, 99) < 35));
    end
    step('0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
